// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Defines the stored entry layout and the queue-wide macros.
`ifndef FQ_DEFINES_SV
`define FQ_DEFINES_SV
`define NOP_INSTR 32'h0000_0000
`define FQ_DEPTH 4
`endif

package fetch_queue_pkg;

    localparam int FQ_DEPTH = `FQ_DEPTH;
    localparam logic [31:0] NOP_INSTR = `NOP_INSTR;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } fq_entry_t;

    localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// Register array backing the fetch queue.
// One synchronous write port, one asynchronous read port.
module fq_ram #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 96
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is never cleared; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode queue with valid/ready on both sides.
// Flush or reset empties the queue on the next edge.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = `FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_pc4,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc4,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;
    fq_entry_t        wr_entry;
    fq_entry_t        rd_entry;
    logic [ENTRY_W-1:0] rd_bits;

    assign count     = count_q;
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_entry.pc    = in_pc;
    assign wr_entry.pc4   = in_pc4;
    assign wr_entry.instr = in_instr;

    fq_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W),
        .W     (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_bits)
    );

    assign rd_entry = fq_entry_t'(rd_bits);

    // Pointer and occupancy update; pointers wrap via natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Head entry to decode, forced to zero/NOP when nothing is queued.
    always_comb begin
        out_pc    = rd_entry.pc;
        out_pc4   = rd_entry.pc4;
        out_instr = rd_entry.instr;
        if (empty) begin
            out_pc    = 32'h0;
            out_pc4   = 32'h0;
            out_instr = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// Directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;
    fq_entry_t mq [$];
    logic [31:0] next_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive, check outputs against model, then advance model.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic rd, input logic fl, input logic rs);
        int sz;
        fq_entry_t hd;
        fq_entry_t e;
        bit pu;
        bit po;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_pc4    = pc + 32'd4;
        in_instr  = $urandom;
        out_ready = rd;
        flush     = fl;
        rst_n     = rs;
        #1;
        if (armed) begin
            sz = mq.size();
            hd = (sz > 0) ? mq[0] : '0;
            check("count", 32'(count), 32'(sz));
            check("empty", 32'(empty), 32'(sz == 0));
            check("full", 32'(full), 32'(sz == 4));
            check("in_ready", 32'(in_ready), 32'(sz < 4));
            check("out_valid", 32'(out_valid), 32'(sz > 0));
            check("out_pc", out_pc, hd.pc);
            check("out_pc4", out_pc4, hd.pc4);
            check("out_instr", out_instr, hd.instr);
        end
        e.pc    = in_pc;
        e.pc4   = in_pc4;
        e.instr = in_instr;
        @(posedge clk);
        if (!rs || fl) begin
            mq.delete();
            armed = 1'b1;
        end else if (armed) begin
            po = rd && (mq.size() > 0);
            pu = v && (mq.size() < 4);
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(e);
        end
    endtask

    task automatic push_pc(input logic rd);
        step(1'b1, next_pc, rd, 1'b0, 1'b1);
        next_pc += 32'd4;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_pc4 = '0;
        in_instr = '0;
        flush = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles while fetch presents data.
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);

        // Fill to full, fifth push held off, then drain.
        next_pc = 32'h0;
        for (int i = 0; i < 4; i++) push_pc(1'b0);
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Wrap-around: two resident, then steady push+pop.
        next_pc = 32'h200;
        push_pc(1'b0);
        push_pc(1'b0);
        for (int i = 0; i < 10; i++) push_pc(1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("wrap_count", 32'(count), 32'd2);

        // Full with pop: in_* must not be written.
        push_pc(1'b0);
        push_pc(1'b0);
        step(1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("full_pop_count", 32'(count), 32'd3);

        // Flush with push and pop in the same cycle.
        step(1'b1, 32'hBEEF_0000, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("flush_next_pc", out_pc, 32'h100);

        // Empty pop.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset.
        next_pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic rd;
            logic fl;
            logic rs;
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 60) != 0);
            step(v, next_pc, rd, fl, rs);
            if (v) next_pc += 32'd4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue that consumes the fetch stage's per-cycle output (pc, pc+4, instruction) and delivers it in order to the decode stage through a valid/ready handshake. It decouples fetch from decode stalls: fetch keeps pushing while the queue has room and holds its PC when the queue is full. A flush input discards all queued instructions when the pipeline redirects on a branch, jump, or exception.

## Interface
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  fetch stage presents a valid entry.
- in_ready  output  1  queue accepts an entry this cycle; equals !full.
- in_pc  input  32  PC of the fetched instruction.
- in_pc4  input  32  pc+4 of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  discard all entries; has priority over push and pop.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  32  head PC; 32'h0 when empty.
- out_pc4  output  32  head pc+4; 32'h0 when empty.
- out_instr  output  32  head instruction; NOP (32'h0) when empty.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- On push, write {in_pc, in_pc4, in_instr} at wr_ptr, then wr_ptr += 1 mod DEPTH.
- On pop, rd_ptr += 1 mod DEPTH.
- count' = count + push - pop. Simultaneous push and pop leave count unchanged and are legal at any occupancy where each is individually enabled. When full, pop with in_valid=1 does not push in that cycle, because in_ready is 0.
- Pointers wrap naturally at DEPTH; full and empty are derived from count, never from pointer equality alone.
- flush: wr_ptr, rd_ptr, and count go to 0 on the next edge. A push or pop in the same cycle is ignored. Storage contents are left unchanged and are not observable.
- Outputs are read combinationally from the storage entry at rd_ptr. When empty, they are forced to 0/NOP.
- No state machine. State consists of the pointers, count, and storage.

## Timing
- Reset (rst_n=0 at an edge): wr_ptr=0, rd_ptr=0, count=0. After reset: in_ready=1, out_valid=0, full=0, empty=1, count=0, out_* = 0. Storage is not cleared.
- Reset in mid-operation behaves exactly like flush. Reset wins over flush.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N. There is no same-cycle bypass from in_* to out_*.
- in_ready depends only on registered state. It has no combinational path from out_ready.
- After a pop at edge N, the next entry appears immediately after edge N. Throughput is one entry per cycle in each direction.
- The flush effect is visible in the cycle after the flush edge: empty=1 and in_ready=1.

## Structure
- define.vh carries `NOP_INSTR (32'h0000_0000) and `FQ_DEPTH (4). The top-level instantiation passes `FQ_DEPTH as DEPTH.
- One sub-module, fq_ram: DEPTH x 96-bit register array with one synchronous write port and one asynchronous read port.
- fetch_queue holds the pointers, count, handshake logic, and output forcing.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> after release, count=0, empty=1, in_ready=1, out_instr=0, out_valid=0.
- Fill and drain: push pc 0x0,0x4,0x8,0xC with out_ready=0 -> full=1, in_ready=0, and a 5th push with pc 0x10 is held off. Then set out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC, then empty=1.
- Wrap-around: run 10 cycles of continuous push and pop with 2 entries resident -> count stays 2, out_pc order is strictly increasing by 4, and pointers wrap past DEPTH-1 with no loss.
- Full with pop: count=4, in_valid=1, out_ready=1 -> count=3 next cycle, and the in_* entry is not written.
- Flush: count=3, with flush=1, in_valid=1, and out_ready=1 in the same cycle -> next cycle count=0 and empty=1. An entry pushed afterwards (pc 0x100) is the next out_pc.
- Empty pop: count=0 with out_ready=1 -> count stays 0, there is no pointer movement, and out_instr=0.
